// File: rtl/puf_capture_pkg.sv
// -----------------------------------------------------------------------------
// puf_capture_pkg
// Shared types and helpers for the PUF response capture block.
//   state_e       : capture FSM states (IDLE, SETTLE, SHIFT)
//   SETTLE_CNT_W  : width of the settle down-counter
//   clog2_min1()  : ceil(log2(value)), never less than 1
// -----------------------------------------------------------------------------
package puf_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SHIFT  = 2'd2
    } state_e;

    // Holds SYNC_STAGES+1 at most; wide enough for any practical chain depth.
    localparam int SETTLE_CNT_W = 8;

    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dff_sync_chain.sv
// -----------------------------------------------------------------------------
// dff_sync_chain
// WIDTH-bit array of SYNC_STAGES-deep flip-flop synchronisers. Free running:
// every stage updates on every rising edge of Clk.
//   Clk   : system clock, rising edge
//   Rst   : asynchronous reset, active-high, clears every stage
//   D     : raw asynchronous inputs
//   DSync : last stage (D as sampled SYNC_STAGES-1 edges before the latest one)
// -----------------------------------------------------------------------------
module dff_sync_chain
    import puf_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] DSync
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= D;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign DSync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/puf_response_capture.sv
// -----------------------------------------------------------------------------
// puf_response_capture
// Captures a WIDTH-bit PUF arbiter response through a synchroniser into a
// parallel register, then shifts it out serially over valid/ready.
//   Clk      : system clock, rising edge
//   Rst      : asynchronous reset, active-high
//   D        : raw arbiter outputs (asynchronous to Clk)
//   Capture  : start request, honoured only in IDLE
//   Busy     : high in SETTLE and SHIFT
//   Q        : last latched response
//   Valid    : Q holds a completed capture
//   SerOut   : current serial bit (0 when not shifting)
//   SerValid : SerOut is offered
//   SerReady : consumer accepts SerOut
//   Done     : one-cycle pulse after the final bit transfers
// Optional build macro PUF_MAJORITY_VOTE_EN: Q is the per-bit majority of the
// chain output on three consecutive edges instead of a single sample.
//
//   state  | meaning
//   IDLE   | waiting for Capture; Q/Valid hold
//   SETTLE | waiting for the captured sample(s) to leave the sync chain
//   SHIFT  | offering Q bit by bit on SerOut
// -----------------------------------------------------------------------------
module puf_response_capture
    import puf_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic             Capture,
    output logic             Busy,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             SerOut,
    output logic             SerValid,
    input  logic             SerReady,
    output logic             Done
);

    localparam int IDX_W = clog2_min1(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    // Edge 1 loads the counter; the latch edge is the one that finds it at 0.
`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SYNC_STAGES + 1);
`else
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SYNC_STAGES - 1);
`endif

    logic [WIDTH-1:0]        d_sync;
    state_e                  state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        latch_val;
    logic [WIDTH-1:0]        q_ordered;

    dff_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk   (Clk),
        .Rst   (Rst),
        .D     (D),
        .DSync (d_sync)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [WIDTH-1:0] samp0_q, samp0_d;
    logic [WIDTH-1:0] samp1_q, samp1_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            samp0_q <= '0;
            samp1_q <= '0;
        end else begin
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
        end
    end

    assign latch_val = (samp0_q & samp1_q) | (samp0_q & d_sync) | (samp1_q & d_sync);
`else
    assign latch_val = d_sync;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        q_d     = q_q;
        valid_d = valid_q;
        done_d  = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
        samp0_d = samp0_q;
        samp1_d = samp1_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Capture) begin
                    state_d = SETTLE;
                    valid_d = 1'b0;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    q_d     = latch_val;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - SETTLE_CNT_W'(1);
`ifdef PUF_MAJORITY_VOTE_EN
                    if (cnt_q == SETTLE_CNT_W'(2)) samp0_d = d_sync;
                    if (cnt_q == SETTLE_CNT_W'(1)) samp1_d = d_sync;
`endif
                end
            end
            SHIFT: begin
                if (SerReady) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reorder once so the serial mux is a plain index for either bit order.
    always_comb begin
        q_ordered = q_q;
        if (MSB_FIRST) begin
            for (int k = 0; k < WIDTH; k++) begin
                q_ordered[k] = q_q[WIDTH-1-k];
            end
        end
    end

    assign SerValid = (state_q == SHIFT);
    assign SerOut   = SerValid & q_ordered[idx_q];
    assign Busy     = (state_q != IDLE);
    assign Q        = q_q;
    assign Valid    = valid_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_puf_response_capture.sv
// -----------------------------------------------------------------------------
// tb_puf_response_capture
// Drives two instances (MSB-first and LSB-first) from the same stimulus and
// compares them against a word-level reference: the expected Q is the sample
// of D at the capture edge (or the majority of three samples when
// PUF_MAJORITY_VOTE_EN is defined), and the expected serial stream is that
// word read out in the instance's bit order.
// -----------------------------------------------------------------------------
module tb_puf_response_capture;

    localparam int W = 8;
    localparam int S = 2;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int LAT = S + 3;
`else
    localparam int LAT = S + 1;
`endif
    localparam int MAX_EDGES = 300;

    logic         Clk;
    logic         Rst;
    logic [W-1:0] D;
    logic         Capture;
    logic         SerReady;
    logic         Busy, Valid, SerOut, SerValid, Done;
    logic [W-1:0] Q;
    logic         Busy_l, Valid_l, SerOut_l, SerValid_l, Done_l;
    logic [W-1:0] Q_l;

    int n_checks = 0;
    int n_fail   = 0;

    puf_response_capture #(.WIDTH(W), .SYNC_STAGES(S), .MSB_FIRST(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .D(D), .Capture(Capture), .Busy(Busy), .Q(Q),
        .Valid(Valid), .SerOut(SerOut), .SerValid(SerValid),
        .SerReady(SerReady), .Done(Done)
    );

    puf_response_capture #(.WIDTH(W), .SYNC_STAGES(S), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .D(D), .Capture(Capture), .Busy(Busy_l), .Q(Q_l),
        .Valid(Valid_l), .SerOut(SerOut_l), .SerValid(SerValid_l),
        .SerReady(SerReady), .Done(Done_l)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"},        Q,        '0);
        check({tag, "_valid"},    Valid,    0);
        check({tag, "_serout"},   SerOut,   0);
        check({tag, "_servalid"}, SerValid, 0);
        check({tag, "_busy"},     Busy,     0);
        check({tag, "_done"},     Done,     0);
        check({tag, "_q_l"},      Q_l,      '0);
        check({tag, "_done_l"},   Done_l,   0);
    endtask

    // mode: 0 = SerReady always 1, 1 = repeating 1,0,0,1, 2 = random.
    // Entered and left at #1 after a rising edge with the design in IDLE.
    task automatic run_capture(input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [W-1:0] d2, input int mode, input bit spurious);
        logic [W-1:0] expq;
        int  e;
        int  nbits;
        bit  ser_exp;
        bit  busy_next;
        bit  rdy;
`ifdef PUF_MAJORITY_VOTE_EN
        expq = (d0 & d1) | (d0 & d2) | (d1 & d2);
`else
        expq = d0;
`endif
        D        = d0;
        Capture  = 1'b1;
        SerReady = 1'b0;
        step();
        e     = 1;
        nbits = 0;
        forever begin
            ser_exp = (e >= LAT) && (nbits < W);
            check("valid",    Valid,    (e >= LAT));
            check("valid_l",  Valid_l,  (e >= LAT));
            check("busy",     Busy,     (e < LAT) || (nbits < W));
            check("servalid", SerValid, ser_exp);
            check("done",     Done,     (nbits == W));
            check("done_l",   Done_l,   (nbits == W));
            if (e >= LAT) begin
                check("q",   Q,   expq);
                check("q_l", Q_l, expq);
            end
            if (ser_exp) begin
                check("serout_msb", SerOut,   expq[W-1-nbits]);
                check("serout_lsb", SerOut_l, expq[nbits]);
            end
            if (nbits == W) break;
            if (e >= MAX_EDGES) begin
                check("timeout_bits", nbits, W);
                break;
            end
            busy_next = (e < LAT) || (nbits < W);
            if (e == 1)      D = d1;
            else if (e == 2) D = d2;
            else             D = W'($urandom);
            Capture = (spurious && busy_next) ? 1'($urandom) : 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((e % 4) == 0) || ((e % 4) == 3);
                default: rdy = 1'($urandom);
            endcase
            SerReady = rdy;
            step();
            e++;
            if (ser_exp && rdy) nbits++;
        end
        if (mode == 0) check("done_edge", e, LAT + W);
        // Done must not repeat; Q/Valid hold in IDLE.
        Capture = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SerReady = 1'($urandom);
            step();
            check("post_done",     Done,     0);
            check("post_busy",     Busy,     0);
            check("post_servalid", SerValid, 0);
            check("post_valid",    Valid,    1);
            check("post_q",        Q,        expq);
        end
    endtask

    initial begin
        Rst      = 1'b1;
        D        = '0;
        Capture  = 1'b0;
        SerReady = 1'b0;
        #2;
        check_all_zero("reset_async");
        #10;
        Rst = 1'b0;
        step();
        check_all_zero("after_reset");

        run_capture(8'hA5, 8'hA5, 8'hA5, 0, 1'b0);
        run_capture(8'hA5, 8'hA5, 8'hA5, 1, 1'b0);
        run_capture(8'hA5, 8'h5A, 8'hA5, 2, 1'b1);
        run_capture(8'h01, 8'h01, 8'h01, 0, 1'b0);
        run_capture(8'hFF, 8'h00, 8'hFF, 0, 1'b0);
        run_capture(8'hF0, 8'hCC, 8'hAA, 0, 1'b0);

        // Reset between edges while shifting abandons the word.
        D       = 8'h5A;
        Capture = 1'b1;
        SerReady = 1'b1;
        step();
        Capture = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();
        check("mid_shift_busy", Busy, 1);
        #3;
        Rst = 1'b1;
        #1;
        check_all_zero("reset_mid_shift");
        #1;
        Rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_done_after_rst", Done, 0);
            check("idle_after_rst",    Busy, 0);
        end
        run_capture(8'h3C, 8'h3C, 8'h3C, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_capture(W'($urandom), W'($urandom), W'($urandom), 2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
